// File: rtl/srambank_pkg.sv
// Shared types and helpers for the banked SRAM macro model.
package srambank_pkg;

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int lanes(input int width, input int byte_w);
        return width / byte_w;
    endfunction

endpackage

// File: rtl/srambank_if.sv
// Request/response bus of the banked SRAM; master drives requests, slave is the array.
interface srambank_if #(
    parameter int AW    = 8,
    parameter int WIDTH = 32,
    parameter int NL    = 4
);
    logic [AW-1:0]    address;
    logic [WIDTH-1:0] wd;
    logic [NL-1:0]    wmask;
    logic             banksel;
    logic             read;
    logic             write;
    logic [WIDTH-1:0] dataout;
    logic             rvalid;
    logic             ready;
    logic             err;

    modport master (
        output address, wd, wmask, banksel, read, write,
        input  dataout, rvalid, ready, err
    );

    modport slave (
        input  address, wd, wmask, banksel, read, write,
        output dataout, rvalid, ready, err
    );
endinterface

// File: rtl/srambank_core.sv
// One DEPTH x WIDTH bank: byte-lane masked write port, enabled read with registered output.
module srambank_core
    import srambank_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 32,
    parameter int BYTE_W = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [WIDTH/BYTE_W-1:0]  be_i,
    input  logic [clog2(DEPTH)-1:0]  addr_i,
    input  logic [WIDTH-1:0]         wd_i,
    input  logic                     re_i,
    output logic [WIDTH-1:0]         rd_o
);
    localparam int NL = lanes(WIDTH, BYTE_W);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NL; l++) begin
            if (we_i && be_i[l]) mem_q[addr_i][l*BYTE_W +: BYTE_W] <= wd_i[l*BYTE_W +: BYTE_W];
        end
        if (re_i) rd_q <= mem_q[addr_i];
    end

    assign rd_o = rd_q;
endmodule

// File: rtl/srambank_array.sv
// NBANKS x DEPTH x WIDTH SRAM model: clear sweep after reset, masked writes,
// 1- or 2-cycle reads with rvalid strobe, sticky protocol error.
module srambank_array
    import srambank_pkg::*;
#(
    parameter int NBANKS         = 4,
    parameter int DEPTH          = 64,
    parameter int WIDTH          = 32,
    parameter int BYTE_W         = 8,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic      clk,
    input  logic      reset,
    srambank_if.slave bus
);
    localparam int RW  = clog2(DEPTH);
    localparam int BW  = clog2(NBANKS);
    localparam int AW  = clog2(NBANKS * DEPTH);
    localparam int NL  = lanes(WIDTH, BYTE_W);
    localparam int BIW = (BW > 0) ? BW : 1;

    state_t           state_q, state_d;
    logic [RW-1:0]    clr_q, clr_d;
    logic             ready, clearing;
    logic [RW-1:0]    row;
    logic [BIW-1:0]   bank;
    logic             req, wr_acc, rd_acc, collide;
    logic [WIDTH-1:0] bank_rd [NBANKS];
    logic             vld_p1_q, have_p1_q;
    logic [BIW-1:0]   bank_p1_q;
    logic [WIDTH-1:0] mux_p1;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == S_INIT) begin
            clr_d = clr_q + 1'b1;
            if (clr_q == RW'(DEPTH - 1)) state_d = S_IDLE;
        end
    end

    always_comb begin
        ready    = 1'b0;
        clearing = 1'b0;
        case (state_q)
            S_INIT: clearing = 1'b1;
            S_IDLE: ready    = 1'b1;
        endcase
    end

    assign row = bus.address[RW-1:0];
    if (BW > 0) begin : g_dec
        assign bank = bus.address[AW-1:RW];
    end else begin : g_nodec
        assign bank = '0;
    end

    // A simultaneous read and write keeps the write and drops the read.
    assign req     = bus.banksel & (bus.read | bus.write);
    assign collide = bus.banksel & bus.read & bus.write;
    assign wr_acc  = ready & bus.banksel & bus.write;
    assign rd_acc  = ready & bus.banksel & bus.read & ~bus.write;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic sel;
        assign sel = (bank == BIW'(b));
        srambank_core #(
            .DEPTH  (DEPTH),
            .WIDTH  (WIDTH),
            .BYTE_W (BYTE_W)
        ) u_core (
            .clk_i  (clk),
            .we_i   (clearing | (wr_acc & sel)),
            .be_i   (clearing ? {NL{1'b1}} : bus.wmask),
            .addr_i (clearing ? clr_q : row),
            .wd_i   (clearing ? '0 : bus.wd),
            .re_i   (rd_acc & sel),
            .rd_o   (bank_rd[b])
        );
    end

    // Stage p1: bank array output, bank index captured with the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q  <= 1'b0;
            have_p1_q <= 1'b0;
            bank_p1_q <= '0;
        end else begin
            vld_p1_q  <= rd_acc;
            have_p1_q <= have_p1_q | rd_acc;
            if (rd_acc) bank_p1_q <= bank;
        end
    end

    // Until the first read after reset the bank registers hold stale data; present zero instead.
    assign mux_p1 = have_p1_q ? bank_rd[bank_p1_q] : '0;

    if (OUT_REG != 0) begin : g_oreg
        // Stage p2: optional output register.
        logic             vld_p2_q;
        logic [WIDTH-1:0] dout_p2_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p2_q  <= 1'b0;
                dout_p2_q <= '0;
            end else begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) dout_p2_q <= mux_p1;
            end
        end
        assign bus.rvalid  = vld_p2_q;
        assign bus.dataout = dout_p2_q;
    end else begin : g_noreg
        assign bus.rvalid  = vld_p1_q;
        assign bus.dataout = mux_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else if ((req && !ready) || (ready && collide)) err_q <= 1'b1;
    end

    assign bus.ready = ready;
    assign bus.err   = err_q;
endmodule
